data_sram_bridge: RTL
=====================

Name: data_sram_bridge

Overview:
- Sits directly downstream of the pipeline's MEM-stage data outputs: memwriteM, sig_write, aluoutM, writedataM.
- Converts the datapath's single-cycle data-memory access into a multi-cycle SRAM-like bus transaction (req/addr_ok/data_ok).
- Returns readdataM to the MEM/WB register.
- Raises a stall to the hazard unit until the access has completed.

Parameters:
ADDR_W, 32, address width of aluoutM and data_addr
DATA_W, 32, data width of read/write data

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
mem_enM  input  1  M-stage instruction is a load or store
memwriteM  input  1  1 = store, 0 = load
mem_sizeM  input  2  0 = byte, 1 = half, 2 = word
sig_write  input  4  store byte strobes
aluoutM  input  ADDR_W  effective address
writedataM  input  DATA_W  pre-aligned store data
flushM  input  1  M-stage instruction is cancelled
stall_ext  input  1  pipeline held by another source (divider, ifetch)
stall_memM  output  1  hold pipeline; access not complete
readdataM  output  DATA_W  load data to MEM/WB
data_req  output  1  bus request
data_wr  output  1  bus write
data_size  output  2  bus size
data_wstrb  output  4  bus byte strobes
data_addr  output  ADDR_W  bus address
data_wdata  output  DATA_W  bus write data
data_addr_ok  input  1  request accepted
data_rdata  input  DATA_W  bus read data
data_data_ok  input  1  response valid

Behaviour:
- Reset (rst=0, async): state=IDLE. All bus outputs are 0. readdataM=0. stall_memM follows its combinational equation (0 when mem_enM=0).
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If mem_enM & ~flushM: latch data_wr/size/wstrb/addr/wdata from the M inputs, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - data_req=1; bus fields come from the latched registers and are held stable.
  - On data_addr_ok, go to DATA.
  - If flushM=1 and data_addr_ok=0: drop data_req next cycle and return to IDLE (cancel).
- DATA:
  - data_req=0.
  - On data_data_ok: capture data_rdata into readdataM and go to DONE.
  - flushM here does not cancel; the response is awaited and its data discarded by the pipeline.
- DONE:
  - readdataM is held.
  - If stall_ext=0, go to IDLE next edge; otherwise stay in DONE.
  - No re-issue of the access while stall_ext holds the pipeline.
- stall_memM = mem_enM & ~flushM & (state != DONE). This is combinational.
- Minimum latency: mem_enM seen in cycle 0; data_req high in cycle 1 with addr_ok; data_ok in cycle 2; stall low in cycle 3. This gives 3 stall cycles.
- Bus rule: data_data_ok arrives no earlier than the cycle after data_addr_ok. One outstanding transaction.
- Stores: readdataM updates with the bus value; the datapath ignores it.
- Back-to-back accesses: DONE→IDLE, then the next mem_enM is seen in IDLE the following cycle.
- data_data_ok while in IDLE or ADDR is a protocol error; the block ignores it.

Optional Feature:
- Macro: DATA_SRAM_BRIDGE_ADDR_MAP_EN.
- Defined: data_addr applies a fixed MIPS segment map. If addr[31:30]==2'b10 (kseg0/kseg1), addr[31:29] is cleared to 3'b000; other addresses pass through.
- Undefined: data_addr = latched aluoutM unchanged.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, ADDR=2'd1, DATA=2'd2, DONE=2'd3.
  - Size constants: SIZE_B, SIZE_H, SIZE_W.
  - Segment constants for the address map.
- One natural sub-module: data_addr_map, the combinational virtual-to-physical translate, instantiated only under the macro.

Test Plan:
1. Load word, addr 0x00001004, addr_ok in cycle 1, data_ok in cycle 2 with rdata 0xDEADBEEF → stall_memM high cycles 0–2; data_req high only in cycle 1; readdataM=0xDEADBEEF in cycle 3 with stall low.
2. Store byte, addr 0x00000003, sig_write 4'b1000, wdata 0xAB000000 → data_wr=1, size=0, wstrb=4'b1000 held stable while addr_ok is delayed 4 cycles; completes after data_ok.
3. stall_ext=1 for 3 cycles after data_ok → state stays DONE, no second data_req, readdataM stable; returns to IDLE when stall_ext drops.
4. flushM asserted in ADDR before addr_ok → data_req low next cycle, state IDLE, stall_memM=0.
5. Reset asserted in DATA → immediately data_req=0, readdataM=0, state IDLE; first access after release issues normally.
6. With DATA_SRAM_BRIDGE_ADDR_MAP_EN: load at 0xBFC00010 → data_addr=0x1FC00010. Without the macro → data_addr=0xBFC00010.

Source files
------------

// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the MEM-stage data SRAM bridge:
// FSM encoding, bus size codes and the kseg0/kseg1 segment map constants.
package data_sram_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   // addr[31:30]==2'b10 selects kseg0/kseg1; both alias physical memory from 0
   localparam logic [1:0] SEG_KSEG01   = 2'b10;
   localparam logic [2:0] SEG_PHYS_TOP = 3'b000;

endpackage

// File: rtl/data_addr_map.sv
// Combinational virtual-to-physical translate: kseg0/kseg1 lose their top three
// address bits, every other address passes through unchanged. Zero latency.
module data_addr_map
   import data_sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] vaddr,
   output logic [ADDR_W-1:0] paddr
);

   always_comb begin
      paddr = vaddr;
      if (vaddr[ADDR_W-1 -: 2] == SEG_KSEG01) begin
         paddr[ADDR_W-1 -: 3] = SEG_PHYS_TOP;
      end
   end

endmodule

// File: rtl/data_sram_bridge.sv
// MEM-stage data access to SRAM-like bus (req/addr_ok/data_ok); stalls the pipeline 3+ cycles
// per access, one transaction outstanding. DATA_SRAM_BRIDGE_ADDR_MAP_EN enables the kseg0/1 map.
module data_sram_bridge
   import data_sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_enM,
   input  logic              memwriteM,
   input  logic [1:0]        mem_sizeM,
   input  logic [3:0]        sig_write,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [DATA_W-1:0] writedataM,
   input  logic              flushM,
   input  logic              stall_ext,
   output logic              stall_memM,
   output logic [DATA_W-1:0] readdataM,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [3:0]        data_wstrb,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic [DATA_W-1:0] data_rdata,
   input  logic              data_data_ok
);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;

   // DONE releases the stall even while stall_ext holds mem_enM high
   assign stall_memM = mem_enM & ~flushM & (state != DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= '0;
         data_wstrb <= '0;
         addr_q     <= '0;
         data_wdata <= '0;
         readdataM  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_enM && !flushM) begin
                  state      <= ADDR;
                  data_req   <= 1'b1;
                  data_wr    <= memwriteM;
                  data_size  <= mem_sizeM;
                  data_wstrb <= sig_write;
                  addr_q     <= aluoutM;
                  data_wdata <= writedataM;
               end
            end
            ADDR: begin
               // an accepted request cannot be recalled, so addr_ok wins over flush
               if (data_addr_ok) begin
                  state    <= DATA;
                  data_req <= 1'b0;
               end else if (flushM) begin
                  state    <= IDLE;
                  data_req <= 1'b0;
               end
            end
            DATA: begin
               if (data_data_ok) begin
                  state     <= DONE;
                  readdataM <= data_rdata;
               end
            end
            DONE: begin
               if (!stall_ext) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DATA_SRAM_BRIDGE_ADDR_MAP_EN
   data_addr_map #(
      .ADDR_W(ADDR_W)
   ) u_addr_map (
      .vaddr(addr_q),
      .paddr(data_addr)
   );
`else
   assign data_addr = addr_q;
`endif

endmodule
